// File: rtl/axi_stream_video_mux_n.sv
// N-input AXI4-Stream video mux; source switches only at frame ends. Registered output.
// Optional macro VMUX_STATS_EN adds drop_cnt_o, one saturating 16-bit discard counter per input.

module vmux_lane #(
  parameter int DRAIN_UNSEL = 1
) (
`ifdef VMUX_STATS_EN
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        i_seek,
  input  logic        i_tvalid,
  input  logic        i_tuser,
  output logic [15:0] o_drop_cnt,
`endif
  input  logic        i_run,
  input  logic        i_act,
  input  logic        i_out_free,
  output logic        o_tready
);
  assign o_tready = i_run && (i_act ? i_out_free : (DRAIN_UNSEL != 0));

`ifdef VMUX_STATS_EN
  logic w_drop;
  logic [15:0] r_cnt;

  // drained beats of an idle lane, or pre-SOF beats thrown away while seeking
  assign w_drop = i_tvalid && o_tready && (!i_act || (i_seek && !i_tuser));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                      r_cnt <= '0;
    else if (w_drop && r_cnt != '1)    r_cnt <= r_cnt + 16'd1;
  end

  assign o_drop_cnt = r_cnt;
`endif
endmodule

module axi_stream_video_mux_n #(
  parameter int NUM_IN      = 4,
  parameter int DW          = 24,
  parameter int SEL_W       = $clog2(NUM_IN),
  parameter int DRAIN_UNSEL = 1
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [NUM_IN*DW-1:0] s_tdata,
  input  logic [NUM_IN-1:0]    s_tvalid,
  output logic [NUM_IN-1:0]    s_tready,
  input  logic [NUM_IN-1:0]    s_tlast,
  input  logic [NUM_IN-1:0]    s_tuser,
  output logic [DW-1:0]        m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 m_tuser,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic [11:0]          lines_i,
  output logic [SEL_W-1:0]     active_sel_o,
  output logic                 switch_pend_o
`ifdef VMUX_STATS_EN
  , output logic [NUM_IN*16-1:0] drop_cnt_o
`endif
);
  localparam logic [0:0] ST_SEEK = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_active;
  logic             r_run;
  logic [11:0]      r_lcnt;
  logic             r_mvalid, r_mlast, r_muser;
  logic [DW-1:0]    r_mdata;

  logic [SEL_W-1:0] w_sel_eff;
  logic [DW-1:0]    w_tdata;
  logic             w_tvalid, w_tlast, w_tuser, w_trdy;
  logic             w_out_free, w_acc, w_fwd, w_frame_end, w_pend;
  logic [11:0]      w_lbase, w_linc;

  // out-of-range requests behave as "stay where we are"
  assign w_sel_eff  = (32'(sel_i) < NUM_IN) ? sel_i : r_active;
  assign w_pend     = (w_sel_eff != r_active);
  assign w_out_free = !r_mvalid || m_tready;

  always_comb begin
    w_tdata  = '0;
    w_tvalid = 1'b0;
    w_tlast  = 1'b0;
    w_tuser  = 1'b0;
    w_trdy   = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_active == SEL_W'(i)) begin
        w_tdata  = s_tdata[i*DW +: DW];
        w_tvalid = s_tvalid[i];
        w_tlast  = s_tlast[i];
        w_tuser  = s_tuser[i];
        w_trdy   = s_tready[i];
      end
    end
  end

  assign w_acc   = w_tvalid && w_trdy;
  assign w_fwd   = w_acc && ((r_state == ST_PASS) || w_tuser);
  // a mid-frame SOF restarts the line count on that very beat
  assign w_lbase = w_tuser ? 12'd0 : r_lcnt;
  assign w_linc  = (w_lbase == 12'hFFF) ? 12'hFFF : w_lbase + 12'd1;
  assign w_frame_end = (r_state == ST_PASS) && w_acc && w_tlast &&
                       ((lines_i == 12'd0) || (w_linc == lines_i));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state  <= ST_SEEK;
      r_active <= '0;
      r_run    <= 1'b0;
      r_lcnt   <= '0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_mlast  <= 1'b0;
      r_muser  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_out_free) begin
        r_mvalid <= w_fwd;
        if (w_fwd) begin
          r_mdata <= w_tdata;
          r_mlast <= w_tlast;
          r_muser <= w_tuser;
        end
      end
      case (r_state)
        ST_SEEK: begin
          if (w_acc && w_tuser) begin
            r_state <= ST_PASS;
            r_lcnt  <= '0;
          end else begin
            r_active <= w_sel_eff;
          end
        end
        ST_PASS: begin
          if (w_acc) begin
            if (w_frame_end) begin
              r_lcnt <= '0;
              if (w_pend) begin
                r_active <= w_sel_eff;
                r_state  <= ST_SEEK;
              end
            end else if (w_tlast) begin
              r_lcnt <= w_linc;
            end else begin
              r_lcnt <= w_lbase;
            end
          end
        end
        default: r_state <= ST_SEEK;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_IN; g++) begin : g_lane
      vmux_lane #(.DRAIN_UNSEL(DRAIN_UNSEL)) u_lane (
`ifdef VMUX_STATS_EN
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .i_seek     (r_state == ST_SEEK),
        .i_tvalid   (s_tvalid[g]),
        .i_tuser    (s_tuser[g]),
        .o_drop_cnt (drop_cnt_o[g*16 +: 16]),
`endif
        .i_run      (r_run),
        .i_act      (r_active == SEL_W'(g)),
        .i_out_free (w_out_free),
        .o_tready   (s_tready[g])
      );
    end
  endgenerate

  assign m_tdata       = r_mdata;
  assign m_tvalid      = r_mvalid;
  assign m_tlast       = r_mlast;
  assign m_tuser       = r_muser;
  assign active_sel_o  = r_active;
  assign switch_pend_o = w_pend;
endmodule

// File: tb/tb_axi_stream_video_mux_n.sv
// Directed bench for axi_stream_video_mux_n; NUM_IN=5 gives a 3-bit select so
// out-of-range requests (5..7) are representable.

module tb_axi_stream_video_mux_n;
  localparam int N  = 5;
  localparam int DW = 24;
  localparam int SW = $clog2(N);

  logic            ACLK = 1'b0;
  logic            ARESETn;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tready, m_tlast, m_tuser;
  logic [SW-1:0]   sel_i;
  logic [11:0]     lines_i;
  logic [SW-1:0]   active_sel_o;
  logic            switch_pend_o;
`ifdef VMUX_STATS_EN
  logic [N*16-1:0] drop_cnt_o;
`endif

  axi_stream_video_mux_n #(.NUM_IN(N), .DW(DW), .DRAIN_UNSEL(1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .sel_i(sel_i), .lines_i(lines_i),
    .active_sel_o(active_sel_o), .switch_pend_o(switch_pend_o)
`ifdef VMUX_STATS_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0, n_fail = 0, stall_err = 0;
  bit bp = 1'b0;
  logic [DW+1:0] q[$];        // {tuser, tlast, tdata}
  logic [DW+1:0] prev_beat;
  bit            prev_stall = 1'b0;

  // output monitor: collect transfers, flag any change while stalled
  always @(posedge ACLK) begin
    if (prev_stall && ({m_tuser, m_tlast, m_tdata} !== prev_beat)) stall_err++;
    if (m_tvalid && m_tready) q.push_back({m_tuser, m_tlast, m_tdata});
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = {m_tuser, m_tlast, m_tdata};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
    if (bp) m_tready = !m_tready;
    #1;
  endtask

  task automatic send(input int i, input int d, input bit l, input bit u);
    logic rdy;
    int   guard = 0;
    s_tdata[i*DW +: DW] = DW'(d);
    s_tlast[i]  = l;
    s_tuser[i]  = u;
    s_tvalid[i] = 1'b1;
    do begin
      rdy = s_tready[i];
      tick();
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input int i, input int base, input int n, input int ppl, input bit fu);
    for (int p = 0; p < n; p++) send(i, base + p, (p % ppl) == ppl - 1, fu && p == 0);
    s_tvalid[i] = 1'b0;
  endtask

  task automatic chk_beats(input string tag, input int base, input int n, input int ppl, input bit fu);
    logic [DW+1:0] e;
    for (int p = 0; p < n; p++) begin
      if (q.size() == 0) begin
        chk({tag, "_missing"}, 64'(p), 64'(n));
        return;
      end
      e = {fu && p == 0, (p % ppl) == ppl - 1, DW'(base + p)};
      chk(tag, 64'(q.pop_front()), 64'(e));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ARESETn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
    sel_i    = '0;
    lines_i  = 12'd4;
    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("rst_sready", 64'(s_tready), 64'd0);
    chk("rst_active", 64'(active_sel_o), 64'd0);
    chk("rst_pend",   64'(switch_pend_o), 64'd0);
    ARESETn = 1'b1;
    tick();
    chk("run_sready", 64'(s_tready), 64'h1F);

    // 1: one 4x8 frame from input 0, first beat visible one cycle after handshake
    send(0, 0, 1'b0, 1'b1);
    chk("t1_lat_valid", 64'(m_tvalid), 64'd1);
    chk("t1_lat_data",  64'({m_tuser, m_tlast, m_tdata}), 64'h2000000);
    for (int p = 1; p < 32; p++) send(0, p, (p % 8) == 7, 1'b0);
    s_tvalid[0] = 1'b0;
    repeat (3) tick();
    chk_beats("t1_beat", 0, 32, 8, 1'b1);
    chk("t1_extra", 64'(q.size()), 64'd0);

    // 2: 50% back-pressure
    bp = 1'b1;
    send_frame(0, 100, 32, 8, 1'b1);
    bp = 1'b0;
    m_tready = 1'b1;
    repeat (3) tick();
    chk_beats("t2_beat", 100, 32, 8, 1'b1);
    chk("t2_extra", 64'(q.size()), 64'd0);
    chk("t2_stall_stable", 64'(stall_err), 64'd0);

    // 3: request input 2 after line 1; switch waits for frame end
    for (int p = 0; p < 8; p++) send(0, 200 + p, (p % 8) == 7, p == 0);
    sel_i = 3'd2;
    #1;
    chk("t3_pend_early",   64'(switch_pend_o), 64'd1);
    chk("t3_active_early", 64'(active_sel_o), 64'd0);
    for (int p = 8; p < 32; p++) begin
      send(0, 200 + p, (p % 8) == 7, 1'b0);
      if (p == 23) begin
        chk("t3_pend_mid",   64'(switch_pend_o), 64'd1);
        chk("t3_active_mid", 64'(active_sel_o), 64'd0);
      end
    end
    s_tvalid[0] = 1'b0;
    chk("t3_active_sw", 64'(active_sel_o), 64'd2);
    chk("t3_pend_sw",   64'(switch_pend_o), 64'd0);
    send(2, 300, 1'b0, 1'b0);
    send(2, 301, 1'b0, 1'b0);
    send(2, 302, 1'b1, 1'b0);
    send_frame(2, 400, 32, 8, 1'b1);
    repeat (3) tick();
    chk_beats("t3_old", 200, 32, 8, 1'b1);
    chk_beats("t3_new", 400, 32, 8, 1'b1);
    chk("t3_extra", 64'(q.size()), 64'd0);

    // 4: inputs 1 and 3 stream while unselected
    s_tdata[1*DW +: DW] = 24'hAA0001;
    s_tdata[3*DW +: DW] = 24'hAA0003;
    s_tuser[1] = 1'b1;
    s_tlast[3] = 1'b1;
    s_tvalid[1] = 1'b1;
    s_tvalid[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t4_rdy1", 64'(s_tready[1]), 64'd1);
      chk("t4_rdy3", 64'(s_tready[3]), 64'd1);
      tick();
    end
    s_tvalid[1] = 1'b0;
    s_tvalid[3] = 1'b0;
    s_tuser[1]  = 1'b0;
    s_tlast[3]  = 1'b0;
    repeat (2) tick();
    chk("t4_no_leak", 64'(q.size()), 64'd0);
    chk("t4_mvalid",  64'(m_tvalid), 64'd0);
`ifdef VMUX_STATS_EN
    chk("t4_drop1", 64'(drop_cnt_o[1*16 +: 16]), 64'd10);
    chk("t4_drop3", 64'(drop_cnt_o[3*16 +: 16]), 64'd10);
    chk("t4_drop2", 64'(drop_cnt_o[2*16 +: 16]), 64'd3);
    chk("t4_drop0", 64'(drop_cnt_o[0*16 +: 16]), 64'd0);
`endif

    // 5: lines_i=0, out-of-range select ignored, then switch at next tlast
    lines_i = 12'd0;
    sel_i   = 3'd5;
    #1;
    chk("t5_pend_ign",   64'(switch_pend_o), 64'd0);
    chk("t5_active_ign", 64'(active_sel_o), 64'd2);
    send_frame(2, 500, 8, 8, 1'b1);
    tick();
    chk("t5_active_hold", 64'(active_sel_o), 64'd2);
    sel_i = 3'd1;
    #1;
    chk("t5_pend", 64'(switch_pend_o), 64'd1);
    send_frame(2, 600, 8, 8, 1'b0);
    chk("t5_active_sw", 64'(active_sel_o), 64'd1);
    chk("t5_pend_sw",   64'(switch_pend_o), 64'd0);
    repeat (2) tick();
    chk_beats("t5_l500", 500, 8, 8, 1'b1);
    chk_beats("t5_l600", 600, 8, 8, 1'b0);
    chk("t5_extra", 64'(q.size()), 64'd0);

    // 6: reset mid-line, then clean restart on input 0
    lines_i = 12'd4;
    send(1, 700, 1'b0, 1'b1);
    send(1, 701, 1'b0, 1'b0);
    send(1, 702, 1'b0, 1'b0);
    chk("t6_pre_valid", 64'(m_tvalid), 64'd1);
    chk("t6_pre_data",  64'(m_tdata), 64'd702);
    ARESETn = 1'b0;
    #1;
    chk("t6_rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_active", 64'(active_sel_o), 64'd0);
    chk("t6_rst_sready", 64'(s_tready), 64'd0);
    s_tvalid[1] = 1'b0;
    sel_i   = 3'd0;
    lines_i = 12'd2;
    q.delete();
    tick();
    ARESETn = 1'b1;
    repeat (2) tick();
    send_frame(0, 800, 8, 4, 1'b1);
    repeat (3) tick();
    chk_beats("t6_restart", 800, 8, 4, 1'b1);
    chk("t6_extra", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
